// File: rtl/sobol_rng.sv
// Sobol low-discrepancy number generator: counts an index, locates its
// least-significant zero and XORs the matching direction vector into the state.
module sobol_rng #(
  parameter int unsigned BITWIDTH    = 4,
  parameter int unsigned LOGBITWIDTH = $clog2(BITWIDTH)
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iDirWe,
  input  logic [LOGBITWIDTH-1:0] iDirAddr,
  input  logic [BITWIDTH-1:0]    iDirData,
  input  logic                   iReady,
  output logic                   oValid,
  output logic [BITWIDTH-1:0]    oSobol,
  output logic [BITWIDTH-1:0]    oCnt,
  output logic                   oWrap
);

  typedef enum logic [0:0] {
    PRIME = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t state, state_next;

  logic [BITWIDTH-1:0]    dir [BITWIDTH];
  logic [BITWIDTH-1:0]    cnt;
  logic [BITWIDTH-1:0]    sobol;
  logic                   wrap;
  logic [LOGBITWIDTH-1:0] lsz;
  logic                   lsz_found;
  logic                   wr_ok;
  logic                   xfer;
  logic                   cnt_full;

  // Zero-extend the address so the bound compare works when BITWIDTH is a power of two.
  assign wr_ok    = iDirWe && ({1'b0, iDirAddr} < (LOGBITWIDTH+1)'(BITWIDTH));
  assign xfer     = (state == RUN) && iReady;
  assign cnt_full = &cnt;

  always_comb begin
    lsz       = '0;
    lsz_found = 1'b0;
    for (int unsigned k = 0; k < BITWIDTH; k++) begin
      if (!lsz_found && !cnt[k]) begin
        lsz       = LOGBITWIDTH'(k);
        lsz_found = 1'b1;
      end
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state <= PRIME;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    oValid     = 1'b0;
    case (state)
      PRIME: begin
        state_next = RUN;
      end
      RUN: begin
        oValid = 1'b1;
      end
      default: begin
        state_next = PRIME;
      end
    endcase
    if (wr_ok) begin
      state_next = PRIME;
    end
  end

  // A direction write takes priority over a same-cycle transfer and restarts the sequence.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      cnt   <= '0;
      sobol <= '0;
      wrap  <= 1'b0;
      for (int unsigned k = 0; k < BITWIDTH; k++) begin
        dir[k] <= BITWIDTH'(1) << (BITWIDTH - 1 - k);
      end
    end else if (wr_ok) begin
      dir[iDirAddr] <= iDirData;
      cnt           <= '0;
      sobol         <= '0;
      wrap          <= 1'b0;
    end else if (xfer) begin
      if (cnt_full) begin
        cnt   <= '0;
        sobol <= '0;
        wrap  <= 1'b1;
      end else begin
        cnt   <= cnt + BITWIDTH'(1);
        sobol <= sobol ^ dir[lsz];
        wrap  <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign oSobol = sobol;
  assign oCnt   = cnt;
  assign oWrap  = wrap;

endmodule

// File: tb/tb_sobol_rng.sv
// Directed bench for sobol_rng: default sequence, backpressure, reprogramming,
// write/transfer collision, async reset and a full 8-bit period.
module tb_sobol_rng;

  logic       clk = 1'b0;
  logic       rst;
  logic       we;
  logic [1:0] addr;
  logic [3:0] data;
  logic       ready;
  logic       valid;
  logic [3:0] sobol;
  logic [3:0] cnt;
  logic       wrap;

  logic       ready8;
  logic       valid8;
  logic [7:0] sobol8;
  logic [7:0] cnt8;
  logic       wrap8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  sobol_rng #(.BITWIDTH(4)) dut (
    .iClk(clk), .iRst(rst), .iDirWe(we), .iDirAddr(addr), .iDirData(data),
    .iReady(ready), .oValid(valid), .oSobol(sobol), .oCnt(cnt), .oWrap(wrap)
  );

  sobol_rng #(.BITWIDTH(8)) dut8 (
    .iClk(clk), .iRst(rst), .iDirWe(1'b0), .iDirAddr(3'd0), .iDirData(8'd0),
    .iReady(ready8), .oValid(valid8), .oSobol(sobol8), .oCnt(cnt8), .oWrap(wrap8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] seq_def  [16] = '{4'd0, 4'd8, 4'd12, 4'd4, 4'd6, 4'd14, 4'd10, 4'd2,
                                4'd3, 4'd11, 4'd15, 4'd7, 4'd5, 4'd13, 4'd9, 4'd1};
  logic [3:0] seq_gray [8]  = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4};
  logic       seen [256];

  initial begin
    int k;
    logic r;
    logic exp_wrap;
    int dups;
    int wraps;

    rst = 1'b1; we = 1'b0; addr = '0; data = '0; ready = 1'b1; ready8 = 1'b0;

    // Reset defaults and the full default period
    step();
    rst = 1'b0;
    chk("rst_valid", valid, 0);
    chk("rst_sobol", sobol, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_wrap", wrap, 0);
    chk("rst_cnt8", cnt8, 0);
    step();
    chk("run_valid", valid, 1);
    for (int i = 0; i < 16; i++) begin
      chk("def_sobol", sobol, seq_def[i]);
      chk("def_cnt", cnt, i);
      chk("def_wrap", wrap, 0);
      step();
    end
    chk("wrap_pulse", wrap, 1);
    chk("wrap_sobol", sobol, 0);
    chk("wrap_cnt", cnt, 0);
    step();
    chk("wrap_clear", wrap, 0);
    chk("after_wrap_sobol", sobol, 8);

    // Backpressure: samples hold while iReady is low, none skipped
    rst = 1'b1;
    #2;
    rst = 1'b0;
    chk("bp_prime", valid, 0);
    step();
    k = 0;
    exp_wrap = 1'b0;
    for (int c = 0; c < 40; c++) begin
      r = 1'($urandom_range(0, 1));
      ready = r;
      chk("bp_sobol", sobol, seq_def[k % 16]);
      chk("bp_cnt", cnt, k % 16);
      chk("bp_wrap", wrap, exp_wrap);
      step();
      if (r) k++;
      exp_wrap = r && (k % 16 == 0);
    end
    ready = 1'b1;

    // Reprogram direction vectors back-to-back to 1,2,4,8
    for (int a = 0; a < 4; a++) begin
      we = 1'b1;
      addr = 2'(a);
      data = 4'(1 << a);
      step();
      chk("wr_valid_low", valid, 0);
      chk("wr_cnt", cnt, 0);
    end
    we = 1'b0;
    step();
    chk("reprog_valid", valid, 1);
    for (int i = 0; i < 8; i++) begin
      chk("gray_sobol", sobol, seq_gray[i]);
      step();
    end

    // Write colliding with a transfer at cnt=5
    we = 1'b1; addr = 2'd3; data = 4'd8;
    step();
    we = 1'b0;
    step();
    for (int i = 0; i < 5; i++) step();
    chk("pre_col_cnt", cnt, 5);
    chk("pre_col_sobol", sobol, 7);
    we = 1'b1; addr = 2'd3; data = 4'd8;
    step();
    we = 1'b0;
    chk("col_valid", valid, 0);
    chk("col_cnt", cnt, 0);
    chk("col_sobol", sobol, 0);
    chk("col_wrap", wrap, 0);
    step();
    chk("col_run_valid", valid, 1);
    step();
    chk("col_next_sobol", sobol, 1);

    // Async reset mid-cycle at cnt=9 restores default direction vectors
    for (int i = 0; i < 8; i++) step();
    chk("pre_rst_cnt", cnt, 9);
    chk("pre_rst_sobol", sobol, 13);
    #3;
    rst = 1'b1;
    #1;
    chk("async_valid", valid, 0);
    chk("async_cnt", cnt, 0);
    chk("async_sobol", sobol, 0);
    step();
    rst = 1'b0;
    chk("rel_prime", valid, 0);
    step();
    chk("rel_s0", sobol, 0);
    step();
    chk("rel_s1", sobol, 8);
    step();
    chk("rel_s2", sobol, 12);

    // BITWIDTH=8 full period
    ready = 1'b0;
    ready8 = 1'b1;
    dups = 0;
    wraps = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int t = 0; t < 256; t++) begin
      if (!valid8) begin
        total++;
        $error("FAIL w8_valid observed=0 expected=1");
      end
      if (seen[sobol8]) dups++;
      seen[sobol8] = 1'b1;
      if (wrap8) wraps++;
      step();
    end
    ready8 = 1'b0;
    chk("w8_dups", dups, 0);
    chk("w8_early_wraps", wraps, 0);
    chk("w8_wrap", wrap8, 1);
    chk("w8_sobol", sobol8, 0);
    chk("w8_cnt", cnt8, 0);
    step();
    chk("w8_wrap_clear", wrap8, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sobol_rng.md
Name: sobol_rng

Overview:
- Sobol-sequence random number generator for the stochastic-computing datapath.
- Counts an index, finds the least-significant-zero position of that index, and XORs the selected direction vector into its state. Each accepted step emits one new low-discrepancy number.
- Acts as the consumer of least-significant-zero indices. Drives comparators that generate unary bitstreams.
- Direction vectors reset to dimension-1 defaults and can be reprogrammed at runtime.

Parameters:
- BITWIDTH, 4, width of the counter, state, output and direction vectors; legal range 2..10.
- LOGBITWIDTH, $clog2(BITWIDTH), width of the direction-vector address and internal LSZ index.

Ports:
- iClk  input  1  clock; all state on rising edge.
- iRst  input  1  asynchronous, active-high reset.
- iDirWe  input  1  direction-vector write strobe.
- iDirAddr  input  LOGBITWIDTH  direction-vector index to write.
- iDirData  input  BITWIDTH  direction-vector value.
- iReady  input  1  downstream accepts oSobol this cycle.
- oValid  output  1  oSobol holds a valid sample.
- oSobol  output  BITWIDTH  current Sobol number.
- oCnt  output  BITWIDTH  index of the current sample.
- oWrap  output  1  one-cycle pulse: the sequence restarted after a full period.

Behaviour:
- Reset (async, iRst=1):
  - cnt=0, oSobol=0, oValid=0, oWrap=0, FSM=PRIME.
  - dir[k] = 1 << (BITWIDTH-1-k) for k = 0..BITWIDTH-1; for BITWIDTH=4 this is 8,4,2,1.
- FSM states:
  - PRIME: oValid=0; always goes to RUN on the next edge.
  - RUN: oValid=1.
  - First valid sample appears exactly 1 cycle after reset release.
- Transfer: oValid & iReady in RUN. Without a transfer, oSobol, oCnt and cnt hold (no drop, no advance).
- On a transfer with cnt != all-ones:
  - idx = position of least-significant 0 in cnt.
  - Next cycle: oSobol <= oSobol ^ dir[idx], cnt <= cnt+1.
- On a transfer with cnt == all-ones (no zero bit):
  - Next cycle: oSobol <= 0, cnt <= 0, oWrap=1 for that one cycle.
  - Period is exactly 2^BITWIDTH samples; each value 0..2^BITWIDTH-1 appears once per period for valid direction vectors.
- oCnt always equals cnt. Latency from transfer to the next sample is 1 cycle, so full throughput is one sample per clock.
- Direction write (iDirWe=1):
  - dir[iDirAddr] <= iDirData at the edge.
  - Sequence restarts: cnt=0, oSobol=0, FSM=PRIME, so oValid=0 for exactly one cycle.
  - iDirAddr >= BITWIDTH: write ignored, no restart.
- Simultaneous write and transfer: the write wins. The transfer is discarded, the sequence restarts, and no oWrap is issued.
- Back-to-back writes keep the FSM in PRIME; oValid returns 1 one cycle after the last write.
- Reset mid-run: immediate async clear of everything, including reloading the default direction vectors.
- Arithmetic is pure XOR and modulo-2^BITWIDTH increment; no saturation.

Test Plan:
- Reset defaults, BITWIDTH=4, iReady=1 held:
  - oValid=0 for the first cycle after release, then 1.
  - oSobol sequence: 0,8,12,4,6,14,10,2,3,11,15,7,5,13,9,1, then 0 with oWrap=1 on that cycle only.
  - oCnt counts 0..15 then 0.
- Backpressure: toggle iReady pseudo-randomly -> the same 16-value order as above. oSobol and oCnt stay stable on every cycle with iReady=0, and no samples are skipped.
- Reprogram dir[0]=4'b0001, dir[1]=4'b0010, dir[2]=4'b0100, dir[3]=4'b1000:
  - oValid low 1 cycle after each write.
  - Then the sequence starts 0,1,3,2,6,7,5,4.
- Write to iDirAddr=3 on the same cycle as a transfer at cnt=5 -> the next cycle gives oValid=0, oCnt=0, oSobol=0, oWrap=0.
- Assert iRst asynchronously mid-cycle at cnt=9 -> outputs clear immediately with no clock edge. After release, the default sequence restarts from 0,8,12.
- BITWIDTH=8, iReady=1 for 256 transfers -> all 256 oSobol values distinct; oWrap pulses exactly once, on the 256th transfer.
